// File: rtl/digit_scroller_pkg.sv
// Shared types and encodings for the digit scroller.
// Holds the FSM state type and the dir/mode encodings used by its ports.
package digit_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;
  localparam logic MODE_ROTATE  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/digit_scroller_step_prescaler.sv
// Step prescaler: counts enabled cycles.
// Pulses tick on every STEP_DIV-th enabled cycle.
module step_prescaler #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // The counter keeps a 1-bit width when STEP_DIV is 1 and stays at zero.
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CW'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/digit_scroller.sv
// Circular digit buffer that scrolls a DIGITS-wide window left or right.
// It can rotate forever, or run once around and then pulse done.
module digit_scroller #(
  parameter int DIGITS     = 8,
  parameter int BUF_DIGITS = 24,
  parameter int DW         = 4,
  parameter int STEP_DIV   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [BUF_DIGITS*DW-1:0]      load_data,
  input  logic                          load_mode,
  input  logic                          dir,
  input  logic                          hold,
  input  logic                          stop,
  output logic [DIGITS*DW-1:0]          win,
  output logic [$clog2(BUF_DIGITS)-1:0] pos,
  output logic                          busy,
  output logic                          done
);
  import digit_scroller_pkg::*;

  localparam int BW = BUF_DIGITS * DW;
  localparam int WW = DIGITS * DW;
  localparam int PW = $clog2(BUF_DIGITS);

  state_t        state_reg;
  logic [BW-1:0] buf_reg;
  logic [PW-1:0] pos_reg;
  logic          mode_reg;
  logic          busy_reg;
  logic          done_reg;

  logic          accept;
  logic          tick;
  logic [BW-1:0] rot_next;
  logic [PW-1:0] pos_next;

  assign load_ready = (state_reg != ST_RUN);
  assign accept     = load_valid && load_ready;

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   ((state_reg == ST_RUN) && !hold),
    .tick (tick)
  );

  // Digit 0 sits in the MS bits, so a left step moves it to the bottom.
  assign rot_next = (dir == DIR_RIGHT) ? {buf_reg[DW-1:0], buf_reg[BW-1:DW]}
                                       : {buf_reg[BW-DW-1:0], buf_reg[BW-1 -: DW]};

  always_comb begin
    pos_next = pos_reg;
    if (dir == DIR_RIGHT) begin
      pos_next = (pos_reg == '0) ? PW'(BUF_DIGITS - 1) : pos_reg - PW'(1);
    end else begin
      pos_next = (pos_reg == PW'(BUF_DIGITS - 1)) ? '0 : pos_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      buf_reg   <= '1;
      pos_reg   <= '0;
      mode_reg  <= MODE_ROTATE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (load_valid) begin
            buf_reg   <= load_data;
            pos_reg   <= '0;
            mode_reg  <= load_mode;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (tick) begin
            buf_reg <= rot_next;
            pos_reg <= pos_next;
            if (mode_reg == MODE_ONESHOT && pos_next == '0) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign win  = buf_reg[BW-1 -: WW];
  assign pos  = pos_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_digit_scroller.sv
// Directed bench for digit_scroller: default instance plus a STEP_DIV=4
// instance used for the hold/prescaler scenario.
module tb_digit_scroller;

  localparam logic [95:0] D0 = 96'hFFFF_FFFF_1234_5678_FFFF_FFFF;
  localparam logic [95:0] D1 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_valid4;
  logic [95:0] load_data;
  logic        load_mode;
  logic        dir;
  logic        hold;
  logic        stop;

  logic [31:0] win;
  logic [4:0]  pos;
  logic        busy, done, load_ready;
  logic [31:0] win4;
  logic [4:0]  pos4;
  logic        busy4, done4, load_ready4;

  int checks   = 0;
  int failures = 0;

  digit_scroller dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_mode(load_mode), .dir(dir), .hold(hold),
    .stop(stop), .win(win), .pos(pos), .busy(busy), .done(done)
  );

  digit_scroller #(.STEP_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid4), .load_ready(load_ready4),
    .load_data(load_data), .load_mode(load_mode), .dir(dir), .hold(hold),
    .stop(stop), .win(win4), .pos(pos4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [95:0] data, input logic mode, input logic d);
    load_valid = 1'b1;
    load_data  = data;
    load_mode  = mode;
    dir        = d;
    tick_n(1);
    load_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_valid = 1'b1;
    load_data = D1;
    tick_n(2);
    checks++; if (win !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_win got=%h exp=ffffffff", win); end
    checks++; if (pos !== 5'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick_n(1);
    $display("test_reset win=%h pos=%0d", win, pos);
  endtask

  task automatic test_rotate_left();
    do_load(D0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || pos !== 5'd0 || load_ready !== 1'b0) begin failures++; $display("FAIL left_load got busy=%b pos=%0d rdy=%b exp 1/0/0", busy, pos, load_ready); end
    tick_n(8);
    checks++; if (win !== 32'h1234_5678) begin failures++; $display("FAIL left8_win got=%h exp=12345678", win); end
    checks++; if (pos !== 5'd8) begin failures++; $display("FAIL left8_pos got=%0d exp=8", pos); end
    tick_n(16);
    checks++; if (win !== 32'hFFFF_FFFF || pos !== 5'd0) begin failures++; $display("FAIL left24 got win=%h pos=%0d exp ffffffff/0", win, pos); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL left24_busy got=%b%b exp=10", busy, done); end
    do_stop();
    $display("test_rotate_left win=%h pos=%0d", win, pos);
  endtask

  task automatic test_rotate_right();
    do_load(D0, 1'b0, 1'b1);
    tick_n(1);
    checks++; if (pos !== 5'd23) begin failures++; $display("FAIL right1_pos got=%0d exp=23", pos); end
    tick_n(15);
    checks++; if (win !== 32'h1234_5678 || pos !== 5'd8) begin failures++; $display("FAIL right16 got win=%h pos=%0d exp 12345678/8", win, pos); end
    do_stop();
    $display("test_rotate_right win=%h pos=%0d", win, pos);
  endtask

  task automatic test_oneshot();
    int done_cnt;
    done_cnt = 0;
    do_load(D0, 1'b1, 1'b0);
    for (int i = 0; i < 23; i++) begin
      tick_n(1);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (pos !== 5'd23 || busy !== 1'b1) begin failures++; $display("FAIL oneshot23 got pos=%0d busy=%b exp 23/1", pos, busy); end
    tick_n(1);
    if (done === 1'b1) done_cnt++;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL oneshot_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("FAIL oneshot_idle got busy=%b rdy=%b exp 0/1", busy, load_ready); end
    checks++; if (win !== 32'hFFFF_FFFF || pos !== 5'd0) begin failures++; $display("FAIL oneshot_win got win=%h pos=%0d exp ffffffff/0", win, pos); end
    for (int i = 0; i < 6; i++) begin
      tick_n(1);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL oneshot_pulses got=%0d exp=1", done_cnt); end
    do_load(D1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || win !== 32'h0123_4567 || pos !== 5'd0) begin failures++; $display("FAIL load_in_done got busy=%b win=%h pos=%0d exp 1/01234567/0", busy, win, pos); end
    do_stop();
    $display("test_oneshot done_pulses=%0d", done_cnt);
  endtask

  task automatic test_hold_prescale();
    dir = 1'b0;
    load_mode = 1'b0;
    load_data = D1;
    load_valid4 = 1'b1;
    tick_n(1);
    load_valid4 = 1'b0;
    checks++; if (win4 !== 32'h0123_4567 || pos4 !== 5'd0) begin failures++; $display("FAIL pre_load got win=%h pos=%0d exp 01234567/0", win4, pos4); end
    tick_n(3);
    checks++; if (pos4 !== 5'd0) begin failures++; $display("FAIL pre_early got pos=%0d exp=0", pos4); end
    tick_n(1);
    checks++; if (win4 !== 32'h1234_5678 || pos4 !== 5'd1) begin failures++; $display("FAIL pre_step1 got win=%h pos=%0d exp 12345678/1", win4, pos4); end
    tick_n(2);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_n(1);
      checks++; if (win4 !== 32'h1234_5678 || pos4 !== 5'd1) begin failures++; $display("FAIL pre_hold cyc=%0d got win=%h pos=%0d exp 12345678/1", i, win4, pos4); end
    end
    hold = 1'b0;
    tick_n(1);
    checks++; if (pos4 !== 5'd1) begin failures++; $display("FAIL pre_after_hold got pos=%0d exp=1", pos4); end
    tick_n(1);
    checks++; if (win4 !== 32'h2345_6789 || pos4 !== 5'd2) begin failures++; $display("FAIL pre_step2 got win=%h pos=%0d exp 23456789/2", win4, pos4); end
    checks++; if (busy4 !== 1'b1 || done4 !== 1'b0 || load_ready4 !== 1'b0) begin failures++; $display("FAIL pre_flags got %b%b%b exp 100", busy4, done4, load_ready4); end
    $display("test_hold_prescale win=%h pos=%0d", win4, pos4);
  endtask

  task automatic test_hold_pending();
    do_load(D0, 1'b0, 1'b0);
    tick_n(2);
    hold = 1'b1;
    tick_n(3);
    checks++; if (pos !== 5'd2) begin failures++; $display("FAIL hold_freeze got pos=%0d exp=2", pos); end
    hold = 1'b0;
    tick_n(1);
    checks++; if (pos !== 5'd3 || win !== 32'hFFFF_F123) begin failures++; $display("FAIL hold_resume got win=%h pos=%0d exp fffff123/3", win, pos); end
    do_stop();
    $display("test_hold_pending pos=%0d", pos);
  endtask

  task automatic test_stop();
    do_load(D0, 1'b0, 1'b0);
    tick_n(3);
    do_stop();
    checks++; if (pos !== 5'd3 || win !== 32'hFFFF_F123) begin failures++; $display("FAIL stop_frozen got win=%h pos=%0d exp fffff123/3", win, pos); end
    checks++; if (busy !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("FAIL stop_idle got busy=%b rdy=%b exp 0/1", busy, load_ready); end
    tick_n(2);
    checks++; if (pos !== 5'd3) begin failures++; $display("FAIL stop_idle_hold got pos=%0d exp=3", pos); end
    do_load(D1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || pos !== 5'd0 || win !== 32'h0123_4567) begin failures++; $display("FAIL stop_reload got busy=%b pos=%0d win=%h", busy, pos, win); end
    do_stop();
    $display("test_stop pos=%0d", pos);
  endtask

  task automatic test_back_to_back();
    do_load(D0, 1'b0, 1'b0);
    tick_n(2);
    load_valid = 1'b1;
    load_data = D1;
    tick_n(1);
    load_valid = 1'b0;
    checks++; if (pos !== 5'd3 || win !== 32'hFFFF_F123) begin failures++; $display("FAIL b2b_ignored got win=%h pos=%0d exp fffff123/3", win, pos); end
    dir = 1'b1;
    tick_n(2);
    checks++; if (pos !== 5'd1) begin failures++; $display("FAIL b2b_dir got pos=%0d exp=1", pos); end
    do_stop();
    $display("test_back_to_back pos=%0d", pos);
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    do_load(D0, 1'b1, 1'b0);
    tick_n(5);
    checks++; if (pos !== 5'd5) begin failures++; $display("FAIL rmid_pre got pos=%0d exp=5", pos); end
    rst_n = 1'b0;
    tick_n(1);
    rst_n = 1'b1;
    checks++; if (win !== 32'hFFFF_FFFF || pos !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_state got win=%h pos=%0d busy=%b done=%b", win, pos, busy, done); end
    for (int i = 0; i < 30; i++) begin
      tick_n(1);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_nodone got pulses=%0d busy=%b exp 0/0", done_cnt, busy); end
    $display("test_reset_mid pos=%0d", pos);
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_valid4 = 1'b0;
    load_data = '0;
    load_mode = 1'b0;
    dir = 1'b0;
    hold = 1'b0;
    stop = 1'b0;
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_oneshot();
    test_hold_prescale();
    test_hold_pending();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
